// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_pkg
//  Description : Shared types and constants for the ADC scaling path:
//                scaler FSM state encoding, default scale/shift constants
//                and the product-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package adc_pkg;

  // Scaler FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    SCALE = 2'd2
  } state_t;

  // Default scaling constants; the averager path uses the same pair
  localparam int unsigned ADC_SCALING_FACTOR = 79993;
  localparam int unsigned ADC_SHIFT_FACTOR   = 19;

  // Product width that holds the full sample * constant without overflow
  function automatic int unsigned adc_prod_w(input int unsigned data_w,
                                             input int unsigned scaling);
    return data_w + int'($clog2(scaling)) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_scale_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. The search starts one
//                past last_grant and wraps; the first asserted request wins.
//                gnt is one-hot and gated by en; gnt_idx is its index.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter  int unsigned N     = 5,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam logic [IDX_W:0] c_n   = (IDX_W+1)'(N);
  localparam logic [IDX_W:0] c_one = (IDX_W+1)'(1);

  logic [IDX_W:0] w_shamt;
  logic [N-1:0]   w_rot;
  logic [IDX_W:0] w_off;
  logic           w_hit;
  logic [IDX_W:0] w_sum;

  // Rotate requests so bit 0 is the channel right after the last grant
  assign w_shamt = {1'b0, last_grant} + c_one;
  assign w_rot   = N'({req, req} >> w_shamt);

  // Find the lowest set bit of the rotated vector (first in search order)
  always_comb begin
    w_off = '0;
    w_hit = 1'b0;
    for (int j = int'(N) - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_hit = 1'b1;
        w_off = (IDX_W+1)'(j);
      end
    end
  end

  // Map the rotated offset back to an absolute channel index and one-hot grant
  always_comb begin
    w_sum = {1'b0, last_grant} + w_off + c_one;
    if (w_sum >= c_n) begin
      w_sum = w_sum - c_n;
    end
    gnt_idx = w_sum[IDX_W-1:0];
    gnt     = '0;
    if (en && w_hit) begin
      gnt = N'(1) << gnt_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_scale_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adc_scale_arbiter
//  Description : Shares one multiply/shift scaling datapath among NUM_CH
//                ADC channels. Round-robin grant with a one-cycle ack, a
//                3-cycle IDLE->MUL->SCALE sequence and a channel-tagged
//                result pulse.
//  Config      : define ADC_SCALE_SATURATE_EN to clamp results above
//                2^OUT_W-1; otherwise the result is truncated (wraps).
//  Revision    : 1.0  initial release
// ============================================================================
module adc_scale_arbiter
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CH         = 5,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned OUT_W          = 16,
  parameter int unsigned SCALING_FACTOR = ADC_SCALING_FACTOR,
  parameter int unsigned SHIFT_FACTOR   = ADC_SHIFT_FACTOR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH*DATA_W-1:0]   din,
  output logic [NUM_CH-1:0]          ack,
  output logic                       out_valid,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  output logic [OUT_W-1:0]           out_data,
  output logic                       busy
);

  localparam int unsigned CH_W   = $clog2(NUM_CH);
  localparam int unsigned PROD_W = adc_prod_w(DATA_W, SCALING_FACTOR);
  localparam logic [PROD_W-1:0] c_scale     = PROD_W'(SCALING_FACTOR);
  localparam logic [CH_W-1:0]   c_last_init = CH_W'(NUM_CH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_arb_en;
  logic                w_grant;
  logic                w_mul;
  logic                w_scale;
  logic [NUM_CH-1:0]   w_gnt;
  logic [CH_W-1:0]     w_gnt_idx;
  logic [CH_W-1:0]     r_last_grant;
  logic [CH_W-1:0]     r_ch;
  logic [DATA_W-1:0]   r_operand;
  logic [PROD_W-1:0]   r_product;
  logic [OUT_W-1:0]    w_result;
  logic [DATA_W-1:0]   w_din_arr [NUM_CH];

  // Unpack the flat sample bus into one word per channel
  for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_unpack
    assign w_din_arr[k] = din[k*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .req        (req),
    .last_grant (r_last_grant),
    .en         (w_arb_en),
    .gnt        (w_gnt),
    .gnt_idx    (w_gnt_idx)
  );

`ifdef ADC_SCALE_SATURATE_EN
  localparam int unsigned SH_W = (PROD_W > OUT_W) ? PROD_W : OUT_W + 1;
  localparam logic [SH_W-1:0] c_out_max = (SH_W'(1) << OUT_W) - SH_W'(1);
  logic [SH_W-1:0] w_shifted;
  assign w_shifted = SH_W'(r_product >> SHIFT_FACTOR);
  // Clamp anything that does not fit the output width to full scale
  assign w_result  = (w_shifted > c_out_max) ? {OUT_W{1'b1}} : OUT_W'(w_shifted);
`else
  // Keep only the low OUT_W bits of the shifted product
  assign w_result  = OUT_W'(r_product >> SHIFT_FACTOR);
`endif

  assign busy = (r_state != IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath enables; requests are only looked at in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_arb_en    = 1'b0;
    w_grant     = 1'b0;
    w_mul       = 1'b0;
    w_scale     = 1'b0;
    case (r_state)
      IDLE: begin
        w_arb_en = 1'b1;
        if (|w_gnt) begin
          w_grant     = 1'b1;
          w_state_nxt = MUL;
        end
      end
      MUL: begin
        w_mul       = 1'b1;
        w_state_nxt = SCALE;
      end
      SCALE: begin
        w_scale     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant capture, multiply and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack          <= '0;
      out_valid    <= 1'b0;
      out_ch       <= '0;
      out_data     <= '0;
      r_last_grant <= c_last_init;
      r_ch         <= '0;
      r_operand    <= '0;
      r_product    <= '0;
    end else begin
      ack       <= w_grant ? w_gnt : '0;
      out_valid <= w_scale;
      if (w_grant) begin
        r_operand    <= w_din_arr[w_gnt_idx];
        r_ch         <= w_gnt_idx;
        r_last_grant <= w_gnt_idx;
      end
      if (w_mul) begin
        r_product <= PROD_W'(r_operand) * c_scale;
      end
      if (w_scale) begin
        out_data <= w_result;
        out_ch   <= r_ch;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_scale_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_scale_arbiter
//  Description : Scoreboard bench for adc_scale_arbiter. Stimulus pushes the
//                expected grant order and results; monitors pop and compare
//                on every ack / out_valid. A second instance with a 2^20
//                scale factor covers the overflow handling.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adc_scale_arbiter;

  typedef struct {
    int ch;
    int data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  req;
  logic [79:0] din;
  logic [4:0]  ack;
  logic        out_valid;
  logic [2:0]  out_ch;
  logic [15:0] out_data;
  logic        busy;

  logic [1:0]  s_req;
  logic [31:0] s_din;
  logic [1:0]  s_ack;
  logic        s_valid;
  logic [0:0]  s_ch;
  logic [15:0] s_data;
  logic        s_busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t q[$];
  int   gq[$];
  exp_t qs[$];
  int   last_ack_cyc = 0;
  logic [4:0] prev_ack = '0;
  logic prev_valid = 1'b0;

  adc_scale_arbiter u_dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .din       (din),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .busy      (busy)
  );

  adc_scale_arbiter #(
    .NUM_CH         (2),
    .SCALING_FACTOR (1048576),
    .SHIFT_FACTOR   (19)
  ) u_sat (
    .clk       (clk),
    .reset     (reset),
    .req       (s_req),
    .din       (s_din),
    .ack       (s_ack),
    .out_valid (s_valid),
    .out_ch    (s_ch),
    .out_data  (s_data),
    .busy      (s_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Grant monitor: order, one-hot, single-cycle pulse
  always @(negedge clk) begin
    if (ack != '0) begin
      check("ack_onehot", int'($onehot(ack)), 1);
      check("ack_single_cycle", int'(prev_ack), 0);
      if (gq.size() == 0) begin
        check("ack_unexpected", int'(ack), 0);
      end else begin
        check("grant_ch", int'(ack), 1 << gq.pop_front());
      end
      last_ack_cyc = cyc;
    end
    prev_ack = ack;
  end

  // Result monitor: latency, channel tag and scaled value
  always @(negedge clk) begin
    if (out_valid) begin
      exp_t e;
      check("valid_single_cycle", int'(prev_valid), 0);
      check("latency", cyc - last_ack_cyc, 2);
      if (q.size() == 0) begin
        check("out_valid_unexpected", int'(out_valid), 0);
      end else begin
        e = q.pop_front();
        check("out_ch", int'(out_ch), e.ch);
        check("out_data", int'(out_data), e.data);
      end
    end
    prev_valid = out_valid;
  end

  // Result monitor for the overflow instance
  always @(negedge clk) begin
    if (s_valid) begin
      exp_t e;
      if (qs.size() == 0) begin
        check("sat_valid_unexpected", int'(s_valid), 0);
      end else begin
        e = qs.pop_front();
        check("sat_out_ch", int'(s_ch), e.ch);
        check("sat_out_data", int'(s_data), e.data);
      end
    end
  end

  task automatic expect_result(input int ch, input int data);
    exp_t e;
    e.ch = ch;
    e.data = data;
    gq.push_back(ch);
    q.push_back(e);
  endtask

  task automatic set_din(input int k, input int v);
    din[k*16 +: 16] = 16'(v);
  endtask

  task automatic wait_any_ack(output logic [4:0] a, output int c);
    a = '0;
    c = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (ack != '0) begin
        a = ack;
        c = cyc;
        break;
      end
    end
  endtask

  // Answer n grants; the first n_re grantees re-raise req one cycle later
  task automatic serve(input int n, input int n_re, input bit spacing);
    logic [4:0] a;
    int c;
    int prev;
    prev = 0;
    for (int i = 0; i < n; i++) begin
      wait_any_ack(a, c);
      check("ack_seen", int'(a != '0), 1);
      check("busy_in_mul", int'(busy), 1);
      if (spacing && i > 0) check("grant_spacing", c - prev, 3);
      prev = c;
      req = req & ~a;
      if (i < n_re) begin
        @(negedge clk);
        req = req | a;
      end
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 40; t++) begin
      if (q.size() == 0 && gq.size() == 0 && qs.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_empty", q.size() + gq.size() + qs.size(), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] a;
    int c;
    int sat_exp;
    reset = 1'b1;
    req   = '0;
    din   = '0;
    s_req = '0;
    s_din = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", int'(ack), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;

    // Single request, full-scale sample on channel 2
    @(posedge clk); #1;
    set_din(2, 65535);
    expect_result(2, 9998);
    req[2] = 1'b1;
    serve(1, 0, 1'b0);
    drain();
    check("busy_idle", int'(busy), 0);

    // Half-scale and zero on channel 0
    @(posedge clk); #1;
    set_din(0, 32768);
    expect_result(0, 4999);
    req[0] = 1'b1;
    serve(1, 0, 1'b0);
    drain();
    @(posedge clk); #1;
    set_din(0, 0);
    expect_result(0, 0);
    req[0] = 1'b1;
    serve(1, 0, 1'b0);
    drain();

    // Overflowing scale on the second instance
`ifdef ADC_SCALE_SATURATE_EN
    sat_exp = 65535;
`else
    sat_exp = 14464;
`endif
    begin
      exp_t e;
      e.ch = 1;
      e.data = sat_exp;
      qs.push_back(e);
    end
    @(posedge clk); #1;
    s_din[31:16] = 16'd40000;
    s_req[1] = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (s_ack != '0) break;
    end
    check("sat_ack", int'(s_ack), 2);
    check("sat_busy", int'(s_busy), 1);
    s_req = '0;
    drain();

    // All five requesting straight after reset: grants 0..4 every 3 cycles
    pulse_reset();
    set_din(0, 16384);
    set_din(1, 32768);
    set_din(2, 49152);
    set_din(3, 65535);
    set_din(4, 8192);
    expect_result(0, 2499);
    expect_result(1, 4999);
    expect_result(2, 7499);
    expect_result(3, 9998);
    expect_result(4, 1249);
    req = 5'h1F;
    serve(5, 0, 1'b1);
    drain();

    // Channels 1 and 3 continuously requesting alternate
    @(posedge clk); #1;
    set_din(1, 8192);
    set_din(3, 49152);
    expect_result(1, 1249);
    expect_result(3, 7499);
    expect_result(1, 1249);
    expect_result(3, 7499);
    req = 5'b01010;
    serve(4, 2, 1'b1);
    drain();

    // Reset while in MUL: in-flight result is dropped, arbiter restarts at 0
    @(posedge clk); #1;
    set_din(2, 100);
    gq.push_back(2);
    req[2] = 1'b1;
    wait_any_ack(a, c);
    check("pre_reset_ack", int'(a), 4);
    #1;
    reset = 1'b1;
    req = '0;
    #1;
    check("mid_rst_ack", int'(ack), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_ch", int'(out_ch), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_busy", int'(busy), 0);
    set_din(0, 65535);
    set_din(4, 32768);
    expect_result(0, 9998);
    expect_result(4, 4999);
    req = 5'b10001;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    serve(2, 0, 1'b1);
    drain();
    repeat (6) @(posedge clk);
    check("final_scoreboard", q.size() + gq.size() + qs.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
